// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised interrupt controller with edge-detected sources and machine timer
module irq_controller #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [2:0]       reg_addr,
    input  logic             reg_we,
    input  logic             reg_re,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             interrupt,
    output logic [2:0]       claim_id
);

    localparam int NID = N_SRC + 1;

    localparam logic [2:0] A_PENDING  = 3'd0;
    localparam logic [2:0] A_ENABLE   = 3'd1;
    localparam logic [2:0] A_CLAIM    = 3'd2;
    localparam logic [2:0] A_MTIME    = 3'd3;
    localparam logic [2:0] A_MTIMECMP = 3'd4;
    localparam logic [2:0] A_CTRL     = 3'd5;
    localparam logic [2:0] A_CLEAR    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [2:0]       prime_q;
    logic [N_SRC:1]   pend_q, edge_det, clr_mask;
    logic [NID:1]     enable_q, eligible;
    logic [31:0]      mtime_q, mtimecmp_q;
    logic             timer_en_q, timer_pend;
    logic [2:0]       best_id;
    logic             take_claim;

    // Edges are masked until the synchronizer and edge flops hold real samples,
    // so a line already high at reset release never looks like a rising edge.
    assign edge_det   = (sync2_q & ~prev_q) & {N_SRC{prime_q[2]}};
    assign timer_pend = timer_en_q && (mtime_q >= mtimecmp_q);
    assign eligible   = {timer_pend, pend_q} & enable_q;
    assign take_claim = (state_q == S_ASSERT) && int_ack && (|eligible);

    always_comb begin
        best_id = 3'd0;
        for (int i = NID; i >= 1; i--) begin
            if (eligible[i]) best_id = 3'(i);
        end
    end

    always_comb begin
        clr_mask = '0;
        if (reg_we && reg_addr == A_CLEAR) clr_mask = reg_wdata[N_SRC:1];
        for (int i = 1; i <= N_SRC; i++) begin
            if (take_claim && best_id == 3'(i)) clr_mask[i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (|eligible) state_d = S_ASSERT;
            S_ASSERT: begin
                if (!(|eligible)) state_d = S_IDLE;
                else if (int_ack) state_d = S_SERVICE;
            end
            S_SERVICE: if (int_done) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            interrupt <= 1'b0;
            claim_id  <= 3'd0;
        end else begin
            state_q   <= state_d;
            interrupt <= (state_d == S_ASSERT);
            if (take_claim) claim_id <= best_id;
            else if (state_q == S_SERVICE && int_done) claim_id <= 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            prime_q <= '0;
            pend_q  <= '0;
        end else begin
            sync1_q <= src_irq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            prime_q <= {prime_q[1:0], 1'b1};
            // A new edge beats a clear landing on the same bit.
            pend_q  <= (pend_q & ~clr_mask) | edge_det;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= 32'hFFFF_FFFF;
            timer_en_q <= 1'b0;
        end else begin
            if (reg_we && reg_addr == A_ENABLE)   enable_q   <= reg_wdata[NID:1];
            if (reg_we && reg_addr == A_MTIMECMP) mtimecmp_q <= reg_wdata;
            if (reg_we && reg_addr == A_CTRL)     timer_en_q <= reg_wdata[0];
            if (reg_we && reg_addr == A_MTIME)    mtime_q    <= reg_wdata;
            else if (timer_en_q)                  mtime_q    <= mtime_q + 32'd1;
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (reg_re) begin
            case (reg_addr)
                A_PENDING:  reg_rdata[N_SRC:1] = pend_q;
                A_ENABLE:   reg_rdata[NID:1]   = enable_q;
                A_CLAIM:    reg_rdata[2:0]     = claim_id;
                A_MTIME:    reg_rdata          = mtime_q;
                A_MTIMECMP: reg_rdata          = mtimecmp_q;
                A_CTRL:     reg_rdata[0]       = timer_en_q;
                default:    reg_rdata          = '0;
            endcase
        end
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N_SRC, default 4: number of external interrupt sources; legal range 1..6.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 src_irq  in  N_SRC  external interrupt request lines; asynchronous; rising-edge sensitive.
REQ-005 reg_addr  in  3  word index of the register being accessed.
REQ-006 reg_we  in  1  register write strobe, one cycle per write.
REQ-007 reg_re  in  1  register read strobe.
REQ-008 reg_wdata  in  32  register write data.
REQ-009 reg_rdata  out  32  register read data.
REQ-010 int_ack  in  1  one-cycle pulse when the core enters the interrupt trap.
REQ-011 int_done  in  1  one-cycle pulse when the core retires mret.
REQ-012 interrupt  out  1  level interrupt request to the exception unit; registered.
REQ-013 claim_id  out  3  ID of the source in service; 0 = none; registered.

Function
REQ-014 Source IDs: external source i -> ID i+1; machine timer -> ID N_SRC+1; lowest ID has highest priority.
REQ-015 Register map (reg_addr):
- 0 PENDING: RO bits [N_SRC:0]; bit 0 unused.
- 1 ENABLE: RW bits [N_SRC+1:1].
- 2 CLAIM: RO, equals claim_id.
- 3 MTIME: RW.
- 4 MTIMECMP: RW.
- 5 CTRL: RW; bit0 = timer_en.
- 6 CLEAR: WO; writing 1 to a bit clears that external pending bit.
REQ-016 Reads: reg_rdata is combinational. It returns the addressed register when reg_re=1 and 0 otherwise. Unused bits and addresses 6-7 read 0.
REQ-017 Each src_irq line passes through a 2-flop synchronizer, then a rising-edge detector. A detected edge sets its PENDING bit on the next clock edge.
REQ-018 Timing: src high first sampled at edge 0 -> PENDING bit readable after edge 2 -> interrupt high after edge 3 (if enabled and FSM in IDLE).
REQ-019 Same-cycle set and CLEAR on one bit: set wins.
REQ-020 MTIME increments by 1 every cycle while timer_en=1 and wraps from 0xFFFFFFFF to 0. A bus write to MTIME overrides the increment in that cycle.
REQ-021 Timer pending is a level, not stored: timer_en & (MTIME >= MTIMECMP), unsigned compare. It is cleared only by raising MTIMECMP, writing MTIME, or clearing timer_en.
REQ-022 eligible = PENDING & ENABLE, with timer pending included.
REQ-023 FSM states: IDLE, ASSERT, SERVICE.
REQ-024 FSM transitions:
- IDLE -> ASSERT when eligible != 0.
- ASSERT -> SERVICE on int_ack.
- ASSERT -> IDLE if eligible drops to 0 before int_ack.
- SERVICE -> IDLE on int_done.
REQ-025 interrupt = 1 exactly while the state is ASSERT. It drops the cycle after int_ack or the cycle after eligible drops to 0.
REQ-026 On the ASSERT->SERVICE edge:
- claim_id loads the highest-priority eligible ID.
- That external PENDING bit clears; the timer bit is not cleared.
REQ-027 On SERVICE->IDLE, claim_id returns to 0. A new ASSERT is possible no earlier than the following edge. No nesting: new pending bits accumulate during SERVICE without asserting interrupt.
REQ-028 int_ack outside ASSERT and int_done outside SERVICE are ignored with no state change.
REQ-029 int_ack and int_done in the same cycle: int_ack is evaluated against the current state only; int_done is ignored unless the state is SERVICE.
REQ-030 Edges arriving while a bit is already pending are merged; they are not counted.

Reset
REQ-031 While rst=0, all of the following hold immediately, independent of clk:
- FSM = IDLE; interrupt = 0; claim_id = 0.
- PENDING, ENABLE, MTIME and CTRL = 0.
- MTIMECMP = 0xFFFFFFFF; synchronizer and edge flops = 0.
REQ-032 Reset mid-service discards the claim. After rst rises, no interrupt asserts until a new edge is detected or the timer condition is met with enables set.
REQ-033 A src_irq line already high when rst releases produces no pending bit; a rising edge is required.

Verification
REQ-034 ENABLE=0x02; pulse src_irq[0] high -> PENDING=0x02 after edge 2, interrupt=1 after edge 3; int_ack -> interrupt=0, claim_id=1, PENDING=0; int_done -> claim_id=0.
REQ-035 ENABLE=0x1E; raise src_irq[2] and src_irq[1] in the same cycle -> int_ack gives claim_id=2; after int_done, interrupt reasserts the next cycle and the second int_ack gives claim_id=3.
REQ-036 Timer: MTIMECMP=10, MTIME=0, ENABLE bit N_SRC+1=1, CTRL=1 -> interrupt=1 once MTIME>=10; int_ack -> claim_id=5 (N_SRC=4); writing MTIMECMP=0xFFFFFFFF in SERVICE removes the pending level.
REQ-037 Wrap: MTIME=0xFFFFFFFE, timer_en=1 -> reads 0xFFFFFFFF, then 0x00000000 on the next cycle.
REQ-038 In ASSERT, write CLEAR=0x02 before int_ack -> interrupt drops the next cycle, FSM returns to IDLE, and a late int_ack leaves claim_id=0.
REQ-039 Drive rst=0 asynchronously mid-SERVICE with claim_id=3 -> claim_id=0, interrupt=0 and ENABLE=0 immediately, with no clock edge required.
